// File: rtl/audio_dma_pkg.sv
// audio_dma_pkg: shared state type and default buffer geometry for the audio capture DMA
package audio_dma_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} dma_state_e;
  localparam logic [11:0] DEF_BASE_ADDR = 12'h800;
  localparam int DEF_FRAME_LEN = 256;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample FIFO (push/pop/din -> dout/full/empty/level), push allowed while full if popping
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/audio_dma_arbiter.sv
// audio_dma_arbiter: gives the cpu priority on the dmem port and drains captured audio samples into a ping-pong frame buffer
module audio_dma_arbiter
  import audio_dma_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dma_enable,
  input  logic                          sample_tick,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          cpu_req,
  input  logic                          cpu_wren,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_data,
  output logic                          ram_wren,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_data,
  output logic                          frame_ready,
  output logic                          frame_bank,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    overflow_count,
  output logic                          busy
);
  localparam int IW = $clog2(FRAME_LEN);
  dma_state_e state;
  logic bank;
  logic [IW-1:0] index;
  logic full, empty, dma_wr, push, run_tick;
  logic [DATA_W-1:0] head;
  assign run_tick = state == RUN && sample_tick;
  assign dma_wr = !reset && !cpu_req && !empty;
  assign push = run_tick && (!full || dma_wr);
  assign busy = state != IDLE;
  assign ram_wren = cpu_req ? cpu_wren : dma_wr;
  assign ram_addr = dma_wr ? BASE_ADDR + ADDR_W'({bank, index}) : cpu_addr;
  assign ram_data = dma_wr ? head : cpu_data;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(dma_wr),
    .din(sample_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bank <= 1'b0;
      index <= '0;
      frame_ready <= 1'b0;
      frame_bank <= 1'b0;
      overflow_count <= '0;
    end else begin
      frame_ready <= dma_wr && &index;
      if (dma_wr) begin
        index <= index + 1'b1;
        if (&index) begin
          bank <= ~bank;
          frame_bank <= bank;
        end
      end
      if (run_tick && full && !dma_wr && overflow_count != 8'hFF) overflow_count <= overflow_count + 1'b1;
      state <= state == IDLE ? (dma_enable ? RUN : IDLE) :
               state == RUN  ? (dma_enable ? RUN : FLUSH) :
               (dma_enable ? RUN : empty ? IDLE : FLUSH);
    end
  end
endmodule

// File: tb/tb_audio_dma_arbiter.sv
// tb_audio_dma_arbiter: directed and randomized checks of audio_dma_arbiter against a queue-based reference model
module tb_audio_dma_arbiter;
  localparam int AW = 12, DW = 32, FL = 256, FD = 4;
  localparam logic [11:0] BASE = 12'h800;
  logic clock = 0, reset = 1, dma_enable = 0, sample_tick = 0, cpu_req = 0, cpu_wren = 0;
  logic [DW-1:0] sample_in = 0, cpu_data = 0;
  logic [AW-1:0] cpu_addr = 0;
  logic ram_wren, frame_ready, frame_bank, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [2:0] fifo_level;
  logic [7:0] overflow_count;
  int tests = 0, fails = 0;
  int mstate = 0, wcount = 0, ovf = 0, pulses = 0;
  int unsigned q[$];
  logic fr_m = 0, fb_m = 0;
  logic o_wren, o_fr;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  always #5 clock = ~clock;
  audio_dma_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .dma_enable(dma_enable), .sample_tick(sample_tick), .sample_in(sample_in),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data), .frame_ready(frame_ready),
    .frame_bank(frame_bank), .fifo_level(fifo_level), .overflow_count(overflow_count), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic en, input logic tk, input logic [31:0] s, input logic rq, input logic wr,
                     input logic [11:0] a, input logic [31:0] d);
    logic dw;
    int pre;
    dma_enable = en; sample_tick = tk; sample_in = s;
    cpu_req = rq; cpu_wren = wr; cpu_addr = a; cpu_data = d;
    #3;
    dw = !reset && !rq && q.size() > 0;
    o_wren = ram_wren; o_addr = ram_addr; o_data = ram_data; o_fr = frame_ready;
    if (!reset) begin
      chk("ram_wren", ram_wren, rq ? wr : dw);
      chk("ram_addr", ram_addr, dw ? BASE + 12'(wcount % (2 * FL)) : a);
      chk("ram_data", ram_data, dw ? q[0] : d);
    end
    chk("fifo_level", fifo_level, q.size());
    chk("overflow_count", overflow_count, ovf);
    chk("busy", busy, mstate != 0);
    chk("frame_ready", frame_ready, fr_m);
    chk("frame_bank", frame_bank, fb_m);
    if (frame_ready) pulses++;
    @(posedge clock);
    if (reset) begin
      mstate = 0; q.delete(); wcount = 0; ovf = 0; fr_m = 0; fb_m = 0;
    end else begin
      pre = q.size();
      fr_m = 0;
      if (dw) begin
        void'(q.pop_front());
        wcount++;
        if (wcount % FL == 0) begin
          fr_m = 1;
          fb_m = 1'(((wcount / FL) - 1) % 2);
        end
      end
      if (mstate == 1 && tk) begin
        if (q.size() < FD) q.push_back(s);
        else if (ovf < 255) ovf++;
      end
      mstate = mstate == 0 ? (en ? 1 : 0) : mstate == 1 ? (en ? 1 : 2) : (en ? 1 : (pre == 0 ? 0 : 2));
    end
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset = 0;
  endtask
  initial begin
    int w;
    logic [31:0] s;
    @(posedge clock);
    #1;
    do_reset();
    chk("rst_wren", ram_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    // single sample goes out the cycle after its tick
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hA5A5_0001, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s1_wren", o_wren, 1);
    chk("s1_addr", o_addr, 12'h800);
    chk("s1_data", o_data, 32'hA5A5_0001);
    chk("s1_level", fifo_level, 0);
    // cpu priority with two pending samples
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h11, 1, 1, 12'h010, 32'hDEAD);
    chk("s2_cpu0", o_addr, 12'h010);
    cyc(1, 1, 32'h22, 1, 1, 12'h010, 32'hDEAD);
    chk("s2_cpu1", o_data, 32'hDEAD);
    cyc(1, 0, 0, 1, 1, 12'h010, 32'hDEAD);
    chk("s2_cpu2", o_addr, 12'h010);
    cyc(1, 0, 0, 0, 0, 12'h010, 0);
    chk("s2_w0", o_addr, 12'h800);
    chk("s2_d0", o_data, 32'h11);
    cyc(1, 0, 0, 0, 0, 12'h010, 0);
    chk("s2_w1", o_addr, 12'h801);
    chk("s2_d1", o_data, 32'h22);
    // full frame and bank swap
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i <= 256; i++) cyc(1, 1, 32'(i), 0, 0, 0, 0);
    chk("s3_last", o_addr, 12'h8FF);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s3_fr", o_fr, 1);
    chk("s3_next", o_addr, 12'h900);
    chk("s3_ndata", o_data, 256);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s3_pulses", pulses, 1);
    chk("s3_bank", frame_bank, 0);
    // overflow with cpu hogging the port
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 32'(100 + i), 1, 0, 0, 0);
    chk("s4_level", fifo_level, 4);
    chk("s4_ovf", overflow_count, 2);
    cyc(1, 1, 32'h77, 0, 0, 0, 0);
    chk("s4_pop_level", fifo_level, 4);
    chk("s4_pop_ovf", overflow_count, 2);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s4_drain", fifo_level, 0);
    // flush after enable drops
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'(200 + i), 1, 0, 0, 0);
    w = 0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    w += int'(o_wren);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 32'hBAD, 0, 0, 0, 0);
      w += int'(o_wren);
    end
    chk("s5_writes", w, 3);
    chk("s5_busy", busy, 0);
    chk("s5_level", fifo_level, 0);
    chk("s5_ovf", overflow_count, 0);
    // reset mid-operation
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(1, 1, 32'(i), 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h1, 1, 0, 0, 0);
    cyc(1, 1, 32'h2, 1, 0, 0, 0);
    reset = 1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s6_nowr", o_wren, 0);
    cyc(1, 1, 32'hC0DE, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("s6_addr", o_addr, 12'h800);
    chk("s6_data", o_data, 32'hC0DE);
    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(299) == 0;
      s = $urandom;
      cyc($urandom_range(7) != 0, $urandom_range(2) == 0, s, $urandom_range(1) == 1,
          $urandom_range(1) == 1, 12'($urandom), $urandom);
    end
    reset = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/audio_dma_arbiter.md
# audio_dma_arbiter

Shares the single data-memory (RAM) port between the processor and an audio sample capture engine. Samples arrive on the 44 kHz sample tick. They are buffered in a small FIFO, then written into a ping-pong frame buffer in dmem during cycles when the processor is not using memory. When a frame fills, the block flags it so the FFT program can process the completed bank while the other bank fills. It sits between `processor` and `RAM` in `Wrapper`.

## Interface
Parameters:
- `ADDR_W`, 12, dmem address width
- `DATA_W`, 32, sample/data width
- `BASE_ADDR`, 12'h800, word address of bank 0
- `FRAME_LEN`, 256, samples per bank; power of two; `2*FRAME_LEN` must fit above `BASE_ADDR`
- `FIFO_DEPTH`, 4, pending-sample slots; power of two

Ports:
- `clock`  in  1  system clock (40 MHz)
- `reset`  in  1  synchronous, active-high
- `dma_enable`  in  1  level; 1 = capture samples
- `sample_tick`  in  1  one-cycle pulse per audio sample
- `sample_in`  in  DATA_W  sample, valid when `sample_tick`=1
- `cpu_req`  in  1  processor is executing lw/sw this cycle
- `cpu_wren`  in  1  processor store enable
- `cpu_addr`  in  ADDR_W  processor dmem address
- `cpu_data`  in  DATA_W  processor store data
- `ram_wren`  out  1  to `RAM.wEn`
- `ram_addr`  out  ADDR_W  to `RAM.addr`
- `ram_data`  out  DATA_W  to `RAM.dataIn`
- `frame_ready`  out  1  one-cycle pulse when a bank completes
- `frame_bank`  out  1  bank that last completed
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied slots
- `overflow_count`  out  8  dropped samples, saturates at 255
- `busy`  out  1  state ≠ IDLE

## Operation
- **States:**
  - IDLE: no capture; FIFO empty.
  - RUN: capture samples and drain the FIFO.
  - FLUSH: drain only.
- **Transitions:**
  - IDLE→RUN when `dma_enable`=1.
  - RUN→FLUSH when `dma_enable`=0.
  - FLUSH→IDLE when the FIFO is empty.
  - FLUSH→RUN if `dma_enable` returns before the FIFO is empty.
- **Enqueue:** in RUN only. When `sample_tick`=1, `sample_in` is pushed. Ticks in IDLE or FLUSH are ignored and are not counted as overflow.
- **Arbitration:** the processor has absolute priority.
  - `cpu_req`=1: `ram_*` = `cpu_*` pass-through. No DMA write that cycle.
  - `cpu_req`=0 and FIFO non-empty: `ram_wren`=1, `ram_addr`=`BASE_ADDR + {bank, index}`, `ram_data`=FIFO head. The entry is popped.
  - Otherwise: `ram_wren`=0, `ram_addr`=`cpu_addr`, `ram_data`=`cpu_data`.
- **Address arithmetic:**
  - `index` is a `$clog2(FRAME_LEN)`-bit counter and increments on each DMA write.
  - When `index` wraps FRAME_LEN-1→0, `bank` toggles, `frame_bank` takes the old bank, and `frame_ready` pulses.
  - The address sum is modulo 2^ADDR_W.
- **Full FIFO:**
  - A tick while full with no pop that cycle: the sample is dropped and `overflow_count` increments (saturating).
  - A tick while full with a pop in the same cycle: the sample is accepted and not counted.
- **Leaving RUN:** `bank` and `index` persist across RUN→FLUSH→IDLE. Only `reset` clears them.

## Timing
- The `ram_*` outputs are a combinational mux of `cpu_*` and registered DMA state. This gives the processor zero added latency.
- Sample latency: a sample ticked in cycle N is written at the earliest in cycle N+1. This requires an empty FIFO and `cpu_req`=0 at N+1.
- `frame_ready` is registered and asserts in the cycle after the DMA write of index FRAME_LEN-1.
- `fifo_level`, `overflow_count` and `busy` are registered and reflect pushes and pops of the previous edge.
- **Reset values:**
  - `ram_wren`=0
  - `frame_ready`=0
  - `frame_bank`=0
  - `fifo_level`=0
  - `overflow_count`=0
  - `busy`=0
  - Internal: state=IDLE, bank=0, index=0, FIFO pointers=0.
- **Reset mid-operation:** takes effect at the next edge regardless of state. Pending samples are discarded and no further DMA write is issued.

## Structure
- Package `audio_dma_pkg`: state enum (IDLE/RUN/FLUSH) and default `BASE_ADDR`/`FRAME_LEN` constants.
- Sub-module `sample_fifo`: synchronous FIFO with push, pop, full, empty and level outputs. It supports simultaneous push and pop when full.
- The top level contains the FSM, arbitration mux, bank/index counters and overflow counter.

## Test plan
- Reset, `dma_enable`=1, one tick with `sample_in`=32'hA5A5_0001, `cpu_req`=0 → next cycle `ram_wren`=1, `ram_addr`=12'h800, `ram_data`=32'hA5A5_0001; `fifo_level` returns to 0.
- `cpu_req`=1 with `cpu_wren`=1 and `cpu_addr`=12'h010 held for 3 cycles while 2 samples are pending → RAM sees only the CPU store during those cycles; the samples are written to 12'h800 and 12'h801 in the two cycles after `cpu_req` drops.
- 256 samples with `cpu_req`=0 → `frame_ready` pulses once, one cycle after the write to 12'h8FF, with `frame_bank`=0; the 257th sample is written to 12'h900.
- `cpu_req` held at 1 while 6 ticks arrive (FIFO_DEPTH=4) → 4 samples are kept and `overflow_count`=2; a tick coinciding with a pop when full is accepted without incrementing the count.
- `dma_enable` dropped with 3 samples pending → FLUSH writes all 3, then IDLE with `busy`=0; ticks during FLUSH are ignored.
- `reset` asserted with 2 samples pending and index=100 → no further DMA writes; after release the next sample is written to 12'h800.
